// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display/status outputs of the stopwatch controller.
// The panel side (buttons, display) is the master; the controller is the slave.
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_clr;
    logic       btn_lap;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic       running;
    logic       lap_active;
    logic       tick;

    modport master (
        output btn_ss, btn_clr, btn_lap,
        input  dig0, dig1, dig2, dig3, running, lap_active, tick
    );

    modport slave (
        input  btn_ss, btn_clr, btn_lap,
        output dig0, dig1, dig2, dig3, running, lap_active, tick
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: M:SS.T counter with start/stop, clear and lap freeze.
// Buttons are synchronized and edge-detected; display muxes live count vs. lap register.
module stopwatch_ctrl #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 10
) (
    input  logic              clk,
    input  logic              rst,
    stopwatch_ctrl_if.slave   bus
);
    localparam int            DIV  = CLK_HZ / TICK_HZ;
    localparam int            PW   = $clog2(DIV);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    // bit 0 = start/stop, bit 1 = clear, bit 2 = lap
    logic [2:0] btn_raw, s1, s2, s3, armed, ev;
    logic [1:0] settle;

    assign btn_raw = {bus.btn_lap, bus.btn_clr, bus.btn_ss};

    // A button is armed only after its synchronized level has been seen low once
    // the synchronizer has settled, so a button held through reset yields no event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            armed  <= '0;
            settle <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            s3 <= s2;
            if (settle != 2'd2) settle <= settle + 2'd1;
            armed <= armed | ({3{settle == 2'd2}} & ~s2);
        end
    end

    assign ev = s2 & ~s3 & armed;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [3:0][3:0] cnt, nxt, lap;
    logic            lap_active, running;
    logic            tick_w;

    assign tick_w = (state == RUN) && (presc == PMAX);

    // Cascaded BCD increment; out-of-range digits fold to zero so the
    // display can never show a non-BCD value.
    always_comb begin
        logic       carry;
        logic [3:0] lim;
        nxt   = cnt;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lim = (i == 2) ? 4'd5 : 4'd9;
            if (carry) begin
                if (cnt[i] >= lim) begin
                    nxt[i] = 4'd0;
                end else begin
                    nxt[i] = cnt[i] + 4'd1;
                    carry  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            cnt        <= '0;
            lap        <= '0;
            lap_active <= 1'b0;
            running    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    presc      <= '0;
                    cnt        <= '0;
                    lap_active <= 1'b0;
                    if (ev[0]) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    presc <= tick_w ? '0 : presc + 1'b1;
                    if (tick_w) cnt <= nxt;
                    // Capture uses the pre-increment count when a tick coincides.
                    if (ev[2]) begin
                        lap_active <= ~lap_active;
                        if (!lap_active) lap <= cnt;
                    end
                    if (ev[0]) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (ev[1]) begin
                        state      <= IDLE;
                        presc      <= '0;
                        cnt        <= '0;
                        lap_active <= 1'b0;
                    end else begin
                        if (ev[0]) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                        if (ev[2]) lap_active <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dig0       = lap_active ? lap[0] : cnt[0];
    assign bus.dig1       = lap_active ? lap[1] : cnt[1];
    assign bus.dig2       = lap_active ? lap[2] : cnt[2];
    assign bus.dig3       = lap_active ? lap[3] : cnt[3];
    assign bus.running    = running;
    assign bus.lap_active = lap_active;
    assign bus.tick       = tick_w;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl at CLK_HZ=100, TICK_HZ=10 (DIV=10).
// Expected displays are queued with stimulus and compared one cycle after each tick.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    stopwatch_ctrl_if sw ();

    stopwatch_ctrl #(.CLK_HZ(100), .TICK_HZ(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_t = -1;
    int n_tick = 0;
    bit pend   = 1'b0;
    int exp_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int bcd(input int t);
        int v;
        v = t % 6000;
        return ((v / 600) % 10) << 12 | ((v / 100) % 6) << 8 |
               ((v / 10) % 10) << 4 | (v % 10);
    endfunction

    function automatic int disp();
        return {16'd0, sw.dig3, sw.dig2, sw.dig1, sw.dig0};
    endfunction

    // Display is compared on the cycle after the tick, once the count has advanced.
    always @(negedge clk) begin
        cyc++;
        if (pend) begin
            pend = 1'b0;
            if (exp_q.size() != 0) chk("dig", disp(), exp_q.pop_front());
        end
        if (sw.tick) begin
            pend = 1'b1;
            n_tick++;
            if (last_t >= 0) chk("tick_gap", cyc - last_t, 10);
            last_t = cyc;
        end
        if (!sw.running) last_t = -1;
    end

    task automatic press(input logic [2:0] m);
        @(negedge clk);
        sw.btn_ss  = m[0];
        sw.btn_clr = m[1];
        sw.btn_lap = m[2];
        repeat (4) @(negedge clk);
        sw.btn_ss  = 1'b0;
        sw.btn_clr = 1'b0;
        sw.btn_lap = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_run(input int from, input int to);
        for (int t = from; t <= to; t++) exp_q.push_back(bcd(t));
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        int t0;
        sw.btn_ss  = 1'b0;
        sw.btn_clr = 1'b0;
        sw.btn_lap = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_dig", disp(), 0);
        chk("rst_running", sw.running, 0);
        chk("rst_lap", sw.lap_active, 0);
        chk("rst_tick", sw.tick, 0);

        // start, 10 ticks to 0:01.0, pause, clear
        press(3'b001);
        chk("start_running", sw.running, 1);
        for (int i = 0; i < 10; i++) exp_q.push_back(bcd(i + 1));
        drain(200);
        chk("one_sec", disp(), 16'h0010);
        press(3'b001);
        chk("pause_running", sw.running, 0);
        t0 = n_tick;
        repeat (30) @(negedge clk);
        chk("pause_no_tick", n_tick - t0, 0);
        chk("pause_hold", disp(), 16'h0010);
        press(3'b010);
        chk("clr_dig", disp(), 0);
        press(3'b100);
        chk("idle_lap_ignored", sw.lap_active, 0);

        // run through 9:59.9 and wrap to 0:00.0
        press(3'b001);
        push_run(1, 6000);
        drain(61000);
        chk("wrap_dig", disp(), 0);
        chk("wrap_running", sw.running, 1);

        // lap freeze at 0:02.3, keep counting to 0:03.8, pause, release
        push_run(1, 23);
        drain(300);
        press(3'b100);
        chk("lap_set", sw.lap_active, 1);
        for (int i = 0; i < 15; i++) exp_q.push_back(bcd(23));
        drain(200);
        press(3'b001);
        chk("lap_pause_running", sw.running, 0);
        chk("lap_pause_frozen", disp(), 16'h0023);
        press(3'b100);
        chk("lap_release", sw.lap_active, 0);
        chk("lap_release_live", disp(), 16'h0038);

        // clear beats start/stop in PAUSE; clear ignored in RUN
        press(3'b011);
        chk("clr_ss_running", sw.running, 0);
        chk("clr_ss_dig", disp(), 0);
        press(3'b001);
        push_run(1, 5);
        drain(100);
        press(3'b010);
        chk("clr_in_run", sw.running, 1);
        push_run(6, 34);
        drain(400);
        chk("pre_rst_dig", disp(), 16'h0034);

        // reset mid-RUN with start/stop held through it
        sw.btn_ss = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_dig", disp(), 0);
        chk("mid_rst_running", sw.running, 0);
        chk("mid_rst_tick", sw.tick, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        t0 = n_tick;
        repeat (30) @(negedge clk);
        chk("held_no_start", sw.running, 0);
        chk("held_no_tick", n_tick - t0, 0);
        chk("held_dig", disp(), 0);
        sw.btn_ss = 1'b0;
        repeat (5) @(negedge clk);
        press(3'b001);
        chk("repress_start", sw.running, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
